sys_cmd_ctrl: RTL and testbench

//  Command controller that consumes UART RX bytes after the data synchronizer.

---
 rtl/sys_cmd_ctrl.sv | 170 +++++++++++++++++
 tb/tb_sys_cmd_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sys_cmd_ctrl.sv
// sys_cmd_ctrl: UART command decoder driving register file, ALU and TX FIFO pushes
module sys_cmd_ctrl #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int ALU_OUT_WIDTH = 16,
  parameter int FUN_WIDTH     = 4
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_WIDTH-1:0]    RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_WIDTH-1:0]    RdData,
  input  logic                     RdData_Valid,
  input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
  input  logic                     OUT_Valid,
  input  logic                     FIFO_FULL,
  output logic                     WrEn,
  output logic                     RdEn,
  output logic [ADDR_WIDTH-1:0]    Address,
  output logic [DATA_WIDTH-1:0]    WrData,
  output logic                     ALU_EN,
  output logic [FUN_WIDTH-1:0]     ALU_FUN,
  output logic                     CLK_GATE_EN,
  output logic [DATA_WIDTH-1:0]    WR_DATA,
  output logic                     WR_INC
);
  typedef enum logic [3:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_OPA, S_OPB,
    S_FUN, S_ALU_WAIT, S_PUSH_LO, S_PUSH_HI
  } state_t;
  state_t                   state_q, state_d;
  logic                     wr_en_q, wr_en_d, rd_en_q, rd_en_d;
  logic [ADDR_WIDTH-1:0]    address_q, address_d;
  logic [DATA_WIDTH-1:0]    reg_data_q, reg_data_d;
  logic                     alu_en_q, alu_en_d, clk_gate_en_q, clk_gate_en_d;
  logic [FUN_WIDTH-1:0]     alu_fun_q, alu_fun_d;
  logic [DATA_WIDTH-1:0]    fifo_data_q, fifo_data_d;
  logic                     wr_inc_q, wr_inc_d;
  logic [ALU_OUT_WIDTH-1:0] result_q, result_d;
  logic                     two_byte_q, two_byte_d;
  logic                     can_push;
  assign can_push = !FIFO_FULL && !wr_inc_q;
  // frame decoding, strobes and push sequencing; a push waits one cycle after the previous one so WR_INC never stays high
  always_comb begin
    state_d       = state_q;
    wr_en_d       = 1'b0;
    rd_en_d       = 1'b0;
    wr_inc_d      = 1'b0;
    address_d     = address_q;
    reg_data_d    = reg_data_q;
    alu_en_d      = alu_en_q;
    clk_gate_en_d = clk_gate_en_q;
    alu_fun_d     = alu_fun_q;
    fifo_data_d   = fifo_data_q;
    result_d      = result_q;
    two_byte_d    = two_byte_q;
    case (state_q)
      S_IDLE:
        if (RX_D_VLD)
          state_d = RX_P_DATA == DATA_WIDTH'(8'hAA) ? S_WR_ADDR :
                    RX_P_DATA == DATA_WIDTH'(8'hBB) ? S_RD_ADDR :
                    RX_P_DATA == DATA_WIDTH'(8'hCC) ? S_OPA :
                    RX_P_DATA == DATA_WIDTH'(8'hDD) ? S_FUN : S_IDLE;
      S_WR_ADDR:
        if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          state_d   = S_WR_DATA;
        end
      S_WR_DATA:
        if (RX_D_VLD) begin
          reg_data_d = RX_P_DATA;
          wr_en_d    = 1'b1;
          state_d    = S_IDLE;
        end
      S_RD_ADDR:
        if (RX_D_VLD) begin
          address_d = RX_P_DATA[ADDR_WIDTH-1:0];
          rd_en_d   = 1'b1;
          state_d   = S_RD_WAIT;
        end
      S_RD_WAIT:
        if (RdData_Valid) begin
          result_d   = ALU_OUT_WIDTH'(RdData);
          two_byte_d = 1'b0;
          state_d    = S_PUSH_LO;
        end
      S_OPA:
        if (RX_D_VLD) begin
          address_d  = ADDR_WIDTH'(0);
          reg_data_d = RX_P_DATA;
          wr_en_d    = 1'b1;
          state_d    = S_OPB;
        end
      S_OPB:
        if (RX_D_VLD) begin
          address_d  = ADDR_WIDTH'(1);
          reg_data_d = RX_P_DATA;
          wr_en_d    = 1'b1;
          state_d    = S_FUN;
        end
      S_FUN:
        if (RX_D_VLD) begin
          alu_fun_d     = RX_P_DATA[FUN_WIDTH-1:0];
          alu_en_d      = 1'b1;
          clk_gate_en_d = 1'b1;
          state_d       = S_ALU_WAIT;
        end
      S_ALU_WAIT:
        if (OUT_Valid) begin
          result_d      = ALU_OUT;
          two_byte_d    = 1'b1;
          alu_en_d      = 1'b0;
          clk_gate_en_d = 1'b0;
          state_d       = S_PUSH_LO;
        end
      S_PUSH_LO:
        if (can_push) begin
          wr_inc_d    = 1'b1;
          fifo_data_d = result_q[DATA_WIDTH-1:0];
          state_d     = two_byte_q ? S_PUSH_HI : S_IDLE;
        end
      S_PUSH_HI:
        if (can_push) begin
          wr_inc_d    = 1'b1;
          fifo_data_d = result_q[ALU_OUT_WIDTH-1:DATA_WIDTH];
          state_d     = S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end
  // state and registered outputs; reset aborts any frame in flight
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      wr_en_q       <= 1'b0;
      rd_en_q       <= 1'b0;
      address_q     <= '0;
      reg_data_q    <= '0;
      alu_en_q      <= 1'b0;
      clk_gate_en_q <= 1'b0;
      alu_fun_q     <= '0;
      fifo_data_q   <= '0;
      wr_inc_q      <= 1'b0;
      result_q      <= '0;
      two_byte_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      rd_en_q       <= rd_en_d;
      address_q     <= address_d;
      reg_data_q    <= reg_data_d;
      alu_en_q      <= alu_en_d;
      clk_gate_en_q <= clk_gate_en_d;
      alu_fun_q     <= alu_fun_d;
      fifo_data_q   <= fifo_data_d;
      wr_inc_q      <= wr_inc_d;
      result_q      <= result_d;
      two_byte_q    <= two_byte_d;
    end
  end
  assign WrEn        = wr_en_q;
  assign RdEn        = rd_en_q;
  assign Address     = address_q;
  assign WrData      = reg_data_q;
  assign ALU_EN      = alu_en_q;
  assign ALU_FUN     = alu_fun_q;
  assign CLK_GATE_EN = clk_gate_en_q;
  assign WR_DATA     = fifo_data_q;
  assign WR_INC      = wr_inc_q;
endmodule

// File: tb/tb_sys_cmd_ctrl.sv
// tb_sys_cmd_ctrl: frame-level scoreboard bench for sys_cmd_ctrl
module tb_sys_cmd_ctrl;
  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  RX_P_DATA = '0;
  logic        RX_D_VLD = 1'b0;
  logic [7:0]  RdData = '0;
  logic        RdData_Valid = 1'b0;
  logic [15:0] ALU_OUT = '0;
  logic        OUT_Valid = 1'b0;
  logic        FIFO_FULL = 1'b0;
  logic        WrEn, RdEn, ALU_EN, CLK_GATE_EN, WR_INC;
  logic [3:0]  Address, ALU_FUN;
  logic [7:0]  WrData, WR_DATA;
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_wr[$];
  logic [3:0]  exp_rd[$];
  logic [7:0]  exp_push[$];
  logic [7:0]  got_push[$];
  logic full_at_edge = 1'b0;
  logic prev_wr = 1'b0, prev_rd = 1'b0, prev_inc = 1'b0;

  sys_cmd_ctrl dut (
    .CLK(CLK), .RST(RST), .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
    .RdData(RdData), .RdData_Valid(RdData_Valid), .ALU_OUT(ALU_OUT),
    .OUT_Valid(OUT_Valid), .FIFO_FULL(FIFO_FULL), .WrEn(WrEn), .RdEn(RdEn),
    .Address(Address), .WrData(WrData), .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN),
    .CLK_GATE_EN(CLK_GATE_EN), .WR_DATA(WR_DATA), .WR_INC(WR_INC)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge CLK) full_at_edge <= FIFO_FULL;

  // compare process: every strobe must match the next expected transaction
  always @(negedge CLK) begin
    if (!RST) begin
      if (WrEn) begin
        if (exp_wr.size() == 0) check("unexpected WrEn", {Address, WrData}, 32'hFFFF_FFFF);
        else check("WrEn addr/data", {Address, WrData}, exp_wr.pop_front());
        check("WrEn with RdEn", RdEn, 0);
        check("WrEn consecutive", prev_wr, 0);
      end
      if (RdEn) begin
        if (exp_rd.size() == 0) check("unexpected RdEn", Address, 32'hFFFF_FFFF);
        else check("RdEn addr", Address, exp_rd.pop_front());
        check("RdEn consecutive", prev_rd, 0);
      end
      if (WR_INC) begin
        got_push.push_back(WR_DATA);
        if (exp_push.size() == 0) check("unexpected WR_INC", WR_DATA, 32'hFFFF_FFFF);
        else check("WR_INC data", WR_DATA, exp_push.pop_front());
        check("WR_INC while full", full_at_edge, 0);
        check("WR_INC consecutive", prev_inc, 0);
      end
      if (ALU_EN || CLK_GATE_EN) check("ALU_EN vs CLK_GATE_EN", ALU_EN, CLK_GATE_EN);
    end
    prev_wr  <= WrEn;
    prev_rd  <= RdEn;
    prev_inc <= WR_INC;
  end

  task automatic send(input logic [7:0] b);
    @(negedge CLK); RX_P_DATA = b; RX_D_VLD = 1'b1;
    @(negedge CLK); RX_D_VLD = 1'b0;
  endtask

  task automatic pulse_rd(input logic [7:0] d);
    @(negedge CLK); RdData = d; RdData_Valid = 1'b1;
    @(negedge CLK); RdData_Valid = 1'b0;
  endtask

  task automatic pulse_alu(input logic [15:0] r);
    @(negedge CLK); ALU_OUT = r; OUT_Valid = 1'b1;
    @(negedge CLK); OUT_Valid = 1'b0;
  endtask

  task automatic wr_frame(input logic [7:0] ab, input logic [7:0] d);
    exp_wr.push_back({ab[3:0], d});
    send(8'hAA); send(ab); send(d);
  endtask

  task automatic rd_frame(input logic [7:0] ab, input logic [7:0] d, input int gap);
    exp_rd.push_back(ab[3:0]);
    exp_push.push_back(d);
    send(8'hBB); send(ab);
    repeat (gap) @(negedge CLK);
    pulse_rd(d);
  endtask

  // command frame up to ALU start; operands land in registers 0 and 1
  task automatic alu_start(input bit ops, input logic [7:0] a, input logic [7:0] b, input logic [7:0] fb);
    if (ops) begin
      exp_wr.push_back({4'h0, a});
      exp_wr.push_back({4'h1, b});
      send(8'hCC); send(a); send(b);
    end else send(8'hDD);
    send(fb);
    check("ALU_EN after FUN", ALU_EN, 1);
    check("CLK_GATE_EN after FUN", CLK_GATE_EN, 1);
    check("ALU_FUN", ALU_FUN, fb[3:0]);
  endtask

  task automatic alu_finish(input logic [15:0] r);
    exp_push.push_back(r[7:0]);
    exp_push.push_back(r[15:8]);
    repeat (3) @(negedge CLK);
    check("ALU_EN held in wait", ALU_EN, 1);
    pulse_alu(r);
    check("ALU_EN dropped", ALU_EN, 0);
    check("CLK_GATE_EN dropped", CLK_GATE_EN, 0);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_wr.size() + exp_rd.size() + exp_push.size()) != 0 && n < 200) begin
      @(negedge CLK);
      n++;
    end
    check({name, " outstanding"}, exp_wr.size() + exp_rd.size() + exp_push.size(), 0);
    repeat (5) @(negedge CLK);
  endtask

  initial begin
    logic [7:0] burst[6];
    #2 RST = 1'b1;
    repeat (2) @(negedge CLK);
    check("reset outputs", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, WR_DATA, WR_INC}, 0);
    RST = 1'b0;
    // 1: register write, address from low nibble only
    got_push.delete();
    wr_frame(8'h03, 8'h5A);
    wr_frame(8'hF7, 8'hC3);
    drain("t1");
    check("t1 no pushes", got_push.size(), 0);
    // 2: register read with 4-cycle latency
    got_push.delete();
    rd_frame(8'h03, 8'h5A, 3);
    drain("t2");
    check("t2 push count", got_push.size(), 1);
    if (got_push.size() == 1) check("t2 push literal", got_push[0], 8'h5A);
    // 3: ALU with operands
    got_push.delete();
    alu_start(1'b1, 8'h05, 8'h07, 8'h06);
    alu_finish(16'h0123);
    drain("t3");
    check("t3 push count", got_push.size(), 2);
    if (got_push.size() == 2) check("t3 push literals", {got_push[0], got_push[1]}, 16'h2301);
    // 4: ALU without operands, function from low nibble
    got_push.delete();
    alu_start(1'b0, 8'h00, 8'h00, 8'hF4);
    alu_finish(16'hBEEF);
    drain("t4");
    check("t4 push count", got_push.size(), 2);
    if (got_push.size() == 2) check("t4 push literals", {got_push[0], got_push[1]}, 16'hEFBE);
    // 5: FIFO full across the push window
    got_push.delete();
    alu_start(1'b1, 8'h05, 8'h07, 8'h06);
    FIFO_FULL = 1'b1;
    alu_finish(16'h0123);
    repeat (10) @(negedge CLK);
    check("t5 no push while full", got_push.size(), 0);
    FIFO_FULL = 1'b0;
    drain("t5");
    check("t5 push count", got_push.size(), 2);
    if (got_push.size() == 2) check("t5 push literals", {got_push[0], got_push[1]}, 16'h2301);
    // back-to-back frames, next header lands the cycle the FSM returns idle
    burst = '{8'hAA, 8'h01, 8'h11, 8'hAA, 8'h02, 8'h22};
    exp_wr.push_back(12'h111);
    exp_wr.push_back(12'h222);
    foreach (burst[i]) begin
      @(negedge CLK); RX_P_DATA = burst[i]; RX_D_VLD = 1'b1;
    end
    @(negedge CLK); RX_D_VLD = 1'b0;
    drain("b2b");
    // 6: reset in ALU_WAIT, stray bytes and pulses
    got_push.delete();
    alu_start(1'b1, 8'h05, 8'h07, 8'h06);
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    #1 check("reset mid-frame outputs", {WrEn, RdEn, Address, WrData, ALU_EN, ALU_FUN, CLK_GATE_EN, WR_DATA, WR_INC}, 0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    pulse_alu(16'h5555);
    pulse_rd(8'h66);
    send(8'h77);
    repeat (5) @(negedge CLK);
    check("t6 no push after reset", got_push.size(), 0);
    wr_frame(8'h09, 8'h3C);
    drain("t6 write");
    exp_rd.push_back(4'h2);
    exp_push.push_back(8'h42);
    send(8'hBB); send(8'h02);
    send(8'hAA);
    pulse_rd(8'h42);
    drain("t6 read");
    wr_frame(8'h0E, 8'h99);
    drain("t6 tail");
    check("t6 push count", got_push.size(), 1);
    if (got_push.size() == 1) check("t6 push literal", got_push[0], 8'h42);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
